// File: rtl/replica_pkg.sv
// ---------------------------------------------------------------
// replica_pkg: shared constants and types for the exp/accept unit. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package replica_pkg;

  localparam int unsigned        ONE_Q15   = 32768;
  localparam int unsigned        EXP_TERMS = 15;
  localparam logic signed [23:0] X_CLAMP   = -24'sd131072;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    WAIT = 2'd2
  } exp_state_t;

endpackage

`default_nettype wire

// File: rtl/exp_horner_step.sv
// ---------------------------------------------------------------
// exp_horner_step: one Horner step, acc_next = 1 + ((x*recip)>>>15)*acc>>>15. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module exp_horner_step (
  input  logic signed [23:0] x_i,
  input  logic        [16:0] recip_i,
  input  logic signed [23:0] acc_i,
  output logic signed [23:0] acc_next_o
);

  logic signed [41:0] xr_prod;
  logic signed [23:0] t_term;
  logic signed [47:0] ta_prod;
  logic               unused_bits;

  // Taking bits [38:15] is an arithmetic shift by 15 followed by truncation to 24 bits.
  assign xr_prod    = x_i * $signed({1'b0, recip_i});
  assign t_term     = $signed(xr_prod[38:15]);
  assign ta_prod    = t_term * acc_i;
  assign acc_next_o = 24'sd32768 + $signed(ta_prod[38:15]);

  assign unused_bits = ^{xr_prod[41:39], xr_prod[14:0], ta_prod[47:39], ta_prod[14:0]};

endmodule

`default_nettype wire

// File: rtl/exp_accept_unit.sv
// ---------------------------------------------------------------
// exp_accept_unit: Taylor exp(x) evaluator and Metropolis accept decision. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module exp_accept_unit
  import replica_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               exp_init,
  input  logic               exp_run,
  input  logic               exp_fin,
  input  logic        [16:0] exp_recip,
  input  logic signed [23:0] delta_x,
  input  logic        [14:0] rnd,
  output logic        [16:0] exp_value,
  output logic               accept,
  output logic               accept_valid,
  output logic               busy,
  output logic               proto_err
);

  localparam logic        [3:0]  TERMS   = 4'(EXP_TERMS);
  localparam logic signed [23:0] ONE_ACC = 24'(ONE_Q15);
  localparam logic        [16:0] ONE_VAL = 17'(ONE_Q15);

  exp_state_t         state_q, state_d;
  logic signed [23:0] x_q, x_d, acc_q, acc_d, acc_step;
  logic        [3:0]  cnt_q, cnt_d;
  logic        [16:0] value_q, value_d, value_next, acc_clamped;
  logic               accept_q, accept_d, accept_next;
  logic               valid_q, valid_d, err_q, err_d;
  logic               run_done;

  exp_horner_step u_step (
    .x_i        (x_q),
    .recip_i    (exp_recip),
    .acc_i      (acc_q),
    .acc_next_o (acc_step)
  );

  always_comb begin
    acc_clamped = acc_q[16:0];
    if (acc_q[23])                acc_clamped = '0;
    else if (acc_q > 24'sd32768)  acc_clamped = ONE_VAL;

    if (!x_q[23])                 value_next = ONE_VAL;
    else if (x_q < X_CLAMP)       value_next = '0;
    else                          value_next = acc_clamped;
    accept_next = !x_q[23] || ({2'b00, rnd} < value_next);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    accept_d = accept_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    // The run phase is over once exp_run has dropped, even before WAIT is registered.
    run_done = (state_q == WAIT) || ((state_q == ITER) && !exp_run);

    if (exp_run) begin
      if ((state_q == ITER) && (cnt_q < TERMS)) begin
        acc_d = acc_step;
        cnt_d = cnt_q + 4'd1;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == ITER) begin
      state_d = WAIT;
    end

    if (exp_fin) begin
      state_d = IDLE;
      if (valid_q) begin
        err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        if (run_done && (cnt_q == TERMS)) begin
          value_d  = value_next;
          accept_d = accept_next;
        end else begin
          accept_d = 1'b0;
          err_d    = 1'b1;
        end
      end
    end

    if (exp_init) begin
      if ((state_q != IDLE) && !exp_fin) err_d = 1'b1;
      x_d     = delta_x;
      acc_d   = ONE_ACC;
      cnt_d   = '0;
      state_d = ITER;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      accept_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      accept_q <= accept_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign exp_value    = value_q;
  assign accept       = accept_q;
  assign accept_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign proto_err    = err_q;

endmodule

`default_nettype wire
